// File: rtl/lc3_ctrl_pkg.sv
// LC-3 control FSM shared definitions:
// state numbers and datapath mux encodings.
package lc3_ctrl_pkg;

  typedef enum logic [5:0] {
    S_BR      = 6'd0,
    S_ADD     = 6'd1,
    S_LD      = 6'd2,
    S_ST      = 6'd3,
    S_JSR     = 6'd4,
    S_AND     = 6'd5,
    S_LDR     = 6'd6,
    S_STR     = 6'd7,
    S_NOT     = 6'd9,
    S_LDI     = 6'd10,
    S_STI     = 6'd11,
    S_JMP     = 6'd12,
    S_LEA     = 6'd14,
    S_TRAP    = 6'd15,
    S_ST_WR   = 6'd16,
    S_FETCH1  = 6'd18,
    S_JSRR    = 6'd20,
    S_JSR_OFF = 6'd21,
    S_BR_TAKE = 6'd22,
    S_ST_MDR  = 6'd23,
    S_LDI_RD  = 6'd24,
    S_LD_RD   = 6'd25,
    S_LDI_MAR = 6'd26,
    S_LD_DR   = 6'd27,
    S_TRAP_RD = 6'd28,
    S_STI_RD  = 6'd29,
    S_TRAP_PC = 6'd30,
    S_STI_MAR = 6'd31,
    S_DECODE  = 6'd32,
    S_FETCH2  = 6'd33,
    S_FETCH3  = 6'd35,
    S_ILL     = 6'd63
  } state_e;

  localparam logic [1:0] PCMUX_INC  = 2'd0;
  localparam logic [1:0] PCMUX_BUS  = 2'd1;
  localparam logic [1:0] PCMUX_ADDR = 2'd2;

  localparam logic       A1_PC      = 1'b0;
  localparam logic       A1_SR1     = 1'b1;

  localparam logic [1:0] A2_ZERO    = 2'd0;
  localparam logic [1:0] A2_OFF6    = 2'd1;
  localparam logic [1:0] A2_OFF9    = 2'd2;
  localparam logic [1:0] A2_OFF11   = 2'd3;

  localparam logic       MM_ZEXT    = 1'b0;
  localparam logic       MM_ADDER   = 1'b1;

  localparam logic       DR_IR      = 1'b0;
  localparam logic       DR_R7      = 1'b1;

  localparam logic       SR1_11_9   = 1'b0;
  localparam logic       SR1_8_6    = 1'b1;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_AND    = 2'd1;
  localparam logic [1:0] ALU_NOT    = 2'd2;
  localparam logic [1:0] ALU_PASSA  = 2'd3;

  localparam logic [3:0] OP_RTI     = 4'd8;
  localparam logic [3:0] OP_RSV     = 4'd13;

endpackage

// File: rtl/lc3_control_fsm.sv
// LC-3 Moore control FSM: fetch, decode and
// execute sequencing with datapath control decode.
module lc3_control_fsm
  import lc3_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        ben,
  input  logic        mem_ready,
  output logic [5:0]  state,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_ben,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic        ld_pc,
  output logic        gate_pc,
  output logic        gate_mdr,
  output logic        gate_alu,
  output logic        gate_marmux,
  output logic [1:0]  pcmux,
  output logic        addr1mux,
  output logic [1:0]  addr2mux,
  output logic        marmux,
  output logic        drmux,
  output logic        sr1mux,
  output logic [1:0]  aluk,
  output logic        mio_en,
  output logic        r_w,
  output logic        illegal
);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] w_op;
  logic       w_unused_ir;

  assign w_op        = ir[15:12];
  assign w_unused_ir = ^ir[10:0];
  assign state       = r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH1;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH1:  w_next = S_FETCH2;
      S_FETCH2:  if (mem_ready) w_next = S_FETCH3;
      S_FETCH3:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_op == OP_RTI || w_op == OP_RSV)
          w_next = S_ILL;
        else
          w_next = state_e'({2'b00, w_op});
      end
      S_BR:      w_next = ben ? S_BR_TAKE : S_FETCH1;
      S_JSR:     w_next = ir[11] ? S_JSR_OFF : S_JSRR;
      S_LD,
      S_LDR:     w_next = S_LD_RD;
      S_LDI:     w_next = S_LDI_RD;
      S_LDI_RD:  if (mem_ready) w_next = S_LDI_MAR;
      S_LDI_MAR: w_next = S_LD_RD;
      S_LD_RD:   if (mem_ready) w_next = S_LD_DR;
      S_ST,
      S_STR:     w_next = S_ST_MDR;
      S_STI:     w_next = S_STI_RD;
      S_STI_RD:  if (mem_ready) w_next = S_STI_MAR;
      S_STI_MAR: w_next = S_ST_MDR;
      S_ST_MDR:  w_next = S_ST_WR;
      S_ST_WR:   if (mem_ready) w_next = S_FETCH1;
      S_TRAP:    w_next = S_TRAP_RD;
      S_TRAP_RD: if (mem_ready) w_next = S_TRAP_PC;
      S_ILL:     w_next = S_ILL;
      default:   w_next = S_FETCH1;
    endcase
  end

  always_comb begin
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    ld_ir       = 1'b0;
    ld_ben      = 1'b0;
    ld_reg      = 1'b0;
    ld_cc       = 1'b0;
    ld_pc       = 1'b0;
    gate_pc     = 1'b0;
    gate_mdr    = 1'b0;
    gate_alu    = 1'b0;
    gate_marmux = 1'b0;
    pcmux       = PCMUX_INC;
    addr1mux    = A1_PC;
    addr2mux    = A2_ZERO;
    marmux      = MM_ZEXT;
    drmux       = DR_IR;
    sr1mux      = SR1_11_9;
    aluk        = ALU_ADD;
    mio_en      = 1'b0;
    r_w         = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH1: begin
        ld_mar  = 1'b1;
        ld_pc   = 1'b1;
        gate_pc = 1'b1;
      end
      S_FETCH2, S_LDI_RD, S_LD_RD, S_STI_RD: begin
        mio_en = 1'b1;
        ld_mdr = 1'b1;
      end
      S_FETCH3: begin
        ld_ir    = 1'b1;
        gate_mdr = 1'b1;
      end
      S_DECODE: ld_ben = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        sr1mux   = SR1_8_6;
        gate_alu = 1'b1;
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
        if (r_state == S_AND) aluk = ALU_AND;
        if (r_state == S_NOT) aluk = ALU_NOT;
      end
      S_BR_TAKE: begin
        ld_pc    = 1'b1;
        pcmux    = PCMUX_ADDR;
        addr2mux = A2_OFF9;
      end
      S_JMP, S_JSRR: begin
        ld_pc    = 1'b1;
        pcmux    = PCMUX_ADDR;
        addr1mux = A1_SR1;
        sr1mux   = SR1_8_6;
      end
      S_JSR: begin
        drmux   = DR_R7;
        gate_pc = 1'b1;
        ld_reg  = 1'b1;
      end
      S_JSR_OFF: begin
        ld_pc    = 1'b1;
        pcmux    = PCMUX_ADDR;
        addr2mux = A2_OFF11;
      end
      S_LD, S_LDI, S_ST, S_STI: begin
        ld_mar      = 1'b1;
        gate_marmux = 1'b1;
        marmux      = MM_ADDER;
        addr2mux    = A2_OFF9;
      end
      S_LDR, S_STR: begin
        ld_mar      = 1'b1;
        gate_marmux = 1'b1;
        marmux      = MM_ADDER;
        addr1mux    = A1_SR1;
        addr2mux    = A2_OFF6;
        sr1mux      = SR1_8_6;
      end
      S_LDI_MAR, S_STI_MAR: begin
        ld_mar   = 1'b1;
        gate_mdr = 1'b1;
      end
      S_LD_DR: begin
        ld_reg   = 1'b1;
        ld_cc    = 1'b1;
        gate_mdr = 1'b1;
      end
      S_LEA: begin
        ld_reg      = 1'b1;
        gate_marmux = 1'b1;
        marmux      = MM_ADDER;
        addr2mux    = A2_OFF9;
      end
      // Store data passes SR straight through the ALU into MDR
      S_ST_MDR: begin
        aluk     = ALU_PASSA;
        gate_alu = 1'b1;
        ld_mdr   = 1'b1;
      end
      S_ST_WR: begin
        mio_en = 1'b1;
        r_w    = 1'b1;
      end
      S_TRAP: begin
        ld_mar      = 1'b1;
        gate_marmux = 1'b1;
      end
      S_TRAP_RD: begin
        mio_en  = 1'b1;
        ld_mdr  = 1'b1;
        drmux   = DR_R7;
        gate_pc = 1'b1;
        ld_reg  = 1'b1;
      end
      S_TRAP_PC: begin
        ld_pc    = 1'b1;
        pcmux    = PCMUX_BUS;
        gate_mdr = 1'b1;
      end
      S_ILL:   illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Scoreboard bench for lc3_control_fsm: directed
// instruction sequences with hand-written state traces.
module tb_lc3_control_fsm;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_pc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       marmux;
    logic       drmux;
    logic       sr1mux;
    logic [1:0] aluk;
    logic       mio_en;
    logic       r_w;
    logic       illegal;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        ben;
  logic        mem_ready;
  logic [5:0]  state;
  ctl_t        d;

  logic [29:0] q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  lc3_control_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .ir          (ir),
    .ben         (ben),
    .mem_ready   (mem_ready),
    .state       (state),
    .ld_mar      (d.ld_mar),
    .ld_mdr      (d.ld_mdr),
    .ld_ir       (d.ld_ir),
    .ld_ben      (d.ld_ben),
    .ld_reg      (d.ld_reg),
    .ld_cc       (d.ld_cc),
    .ld_pc       (d.ld_pc),
    .gate_pc     (d.gate_pc),
    .gate_mdr    (d.gate_mdr),
    .gate_alu    (d.gate_alu),
    .gate_marmux (d.gate_marmux),
    .pcmux       (d.pcmux),
    .addr1mux    (d.addr1mux),
    .addr2mux    (d.addr2mux),
    .marmux      (d.marmux),
    .drmux       (d.drmux),
    .sr1mux      (d.sr1mux),
    .aluk        (d.aluk),
    .mio_en      (d.mio_en),
    .r_w         (d.r_w),
    .illegal     (d.illegal)
  );

  // Expected controls for each state, written from the state table
  function automatic ctl_t ectl(input logic [5:0] s);
    ctl_t c;
    c = '0;
    case (s)
      6'd18: begin c.ld_mar = 1; c.ld_pc = 1; c.gate_pc = 1; end
      6'd33, 6'd24, 6'd25, 6'd29: begin c.mio_en = 1; c.ld_mdr = 1; end
      6'd35: begin c.ld_ir = 1; c.gate_mdr = 1; end
      6'd32: c.ld_ben = 1;
      6'd1, 6'd5, 6'd9: begin
        c.sr1mux = 1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
        c.aluk = (s == 6'd5) ? 2'd1 : (s == 6'd9) ? 2'd2 : 2'd0;
      end
      6'd22: begin c.ld_pc = 1; c.pcmux = 2; c.addr2mux = 2; end
      6'd12, 6'd20: begin
        c.ld_pc = 1; c.pcmux = 2; c.addr1mux = 1; c.sr1mux = 1;
      end
      6'd4: begin c.drmux = 1; c.gate_pc = 1; c.ld_reg = 1; end
      6'd21: begin c.ld_pc = 1; c.pcmux = 2; c.addr2mux = 3; end
      6'd2, 6'd10, 6'd3, 6'd11: begin
        c.ld_mar = 1; c.gate_marmux = 1; c.marmux = 1; c.addr2mux = 2;
      end
      6'd6, 6'd7: begin
        c.ld_mar = 1; c.gate_marmux = 1; c.marmux = 1;
        c.addr1mux = 1; c.addr2mux = 1; c.sr1mux = 1;
      end
      6'd26, 6'd31: begin c.ld_mar = 1; c.gate_mdr = 1; end
      6'd27: begin c.ld_reg = 1; c.ld_cc = 1; c.gate_mdr = 1; end
      6'd14: begin
        c.ld_reg = 1; c.gate_marmux = 1; c.marmux = 1; c.addr2mux = 2;
      end
      6'd23: begin c.aluk = 3; c.gate_alu = 1; c.ld_mdr = 1; end
      6'd16: begin c.mio_en = 1; c.r_w = 1; end
      6'd15: begin c.ld_mar = 1; c.gate_marmux = 1; end
      6'd28: begin
        c.mio_en = 1; c.ld_mdr = 1; c.drmux = 1;
        c.gate_pc = 1; c.ld_reg = 1;
      end
      6'd30: begin c.ld_pc = 1; c.pcmux = 1; c.gate_mdr = 1; end
      6'd63: c.illegal = 1;
      default: ;
    endcase
    return c;
  endfunction

  // Drive inputs for the next edge and queue the state expected after it
  task automatic st(input logic r, input logic [15:0] i,
                    input logic b, input logic m,
                    input logic [5:0] s);
    @(negedge clk);
    rst = r; ir = i; ben = b; mem_ready = m;
    q.push_back({s, ectl(s)});
  endtask

  task automatic seq(input logic [15:0] i, input logic b,
                     input int n, input logic [47:0] ss);
    for (int k = 0; k < n; k++)
      st(1'b0, i, b, 1'b1, ss[6*(n-1-k) +: 6]);
  endtask

  initial begin : monitor
    logic [29:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({state, d} !== e) begin
          n_err++;
          $display("FAIL vec%0d: got state=%0d ctl=%h, want state=%0d ctl=%h",
                   n_vec, state, d, e[29:24], e[23:0]);
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1; ir = '0; ben = 1'b0; mem_ready = 1'b0;
    st(1, 16'h0000, 0, 0, 18);
    seq(16'h1262, 0, 5, 48'({6'd33, 6'd35, 6'd32, 6'd1, 6'd18}));
    seq(16'h0E05, 1, 6, 48'({6'd33, 6'd35, 6'd32, 6'd0, 6'd22, 6'd18}));
    seq(16'h0E05, 0, 5, 48'({6'd33, 6'd35, 6'd32, 6'd0, 6'd18}));
    // LDI with two wait cycles in each of 33, 24 and 25
    st(0, 16'hA000, 0, 1, 33);
    st(0, 16'hA000, 0, 0, 33);
    st(0, 16'hA000, 0, 0, 33);
    st(0, 16'hA000, 0, 1, 35);
    st(0, 16'hA000, 0, 1, 32);
    st(0, 16'hA000, 0, 1, 10);
    st(0, 16'hA000, 0, 1, 24);
    st(0, 16'hA000, 0, 0, 24);
    st(0, 16'hA000, 0, 0, 24);
    st(0, 16'hA000, 0, 1, 26);
    st(0, 16'hA000, 0, 1, 25);
    st(0, 16'hA000, 0, 0, 25);
    st(0, 16'hA000, 0, 0, 25);
    st(0, 16'hA000, 0, 1, 27);
    st(0, 16'hA000, 0, 1, 18);
    // STI with the final write held off two cycles
    seq(16'hB000, 0, 8,
        {6'd33, 6'd35, 6'd32, 6'd11, 6'd29, 6'd31, 6'd23, 6'd16});
    st(0, 16'hB000, 0, 0, 16);
    st(0, 16'hB000, 0, 0, 16);
    st(0, 16'hB000, 0, 1, 18);
    seq(16'hF025, 0, 7,
        48'({6'd33, 6'd35, 6'd32, 6'd15, 6'd28, 6'd30, 6'd18}));
    seq(16'h4800, 0, 6, 48'({6'd33, 6'd35, 6'd32, 6'd4, 6'd21, 6'd18}));
    seq(16'h4040, 0, 6, 48'({6'd33, 6'd35, 6'd32, 6'd4, 6'd20, 6'd18}));
    seq(16'h2000, 0, 7,
        48'({6'd33, 6'd35, 6'd32, 6'd2, 6'd25, 6'd27, 6'd18}));
    seq(16'h6000, 0, 7,
        48'({6'd33, 6'd35, 6'd32, 6'd6, 6'd25, 6'd27, 6'd18}));
    seq(16'h3000, 0, 7,
        48'({6'd33, 6'd35, 6'd32, 6'd3, 6'd23, 6'd16, 6'd18}));
    seq(16'h7000, 0, 7,
        48'({6'd33, 6'd35, 6'd32, 6'd7, 6'd23, 6'd16, 6'd18}));
    seq(16'hE000, 0, 5, 48'({6'd33, 6'd35, 6'd32, 6'd14, 6'd18}));
    seq(16'h903F, 0, 5, 48'({6'd33, 6'd35, 6'd32, 6'd9, 6'd18}));
    seq(16'h5000, 0, 5, 48'({6'd33, 6'd35, 6'd32, 6'd5, 6'd18}));
    seq(16'hC1C0, 0, 5, 48'({6'd33, 6'd35, 6'd32, 6'd12, 6'd18}));
    // RTI traps and stays until reset
    seq(16'h8000, 0, 4, 48'({6'd33, 6'd35, 6'd32, 6'd63}));
    for (int k = 0; k < 10; k++) begin
      logic [1:0] v;
      v = k[1:0];
      st(0, 16'h8000, v[0], v[1], 63);
    end
    st(1, 16'h8000, 0, 1, 18);
    seq(16'hD000, 0, 5, 48'({6'd33, 6'd35, 6'd32, 6'd63, 6'd63}));
    st(1, 16'hD000, 0, 1, 18);
    // Reset while waiting on memory in state 25
    seq(16'h2000, 0, 5, 48'({6'd33, 6'd35, 6'd32, 6'd2, 6'd25}));
    st(1, 16'h2000, 0, 0, 18);
    st(0, 16'h2000, 0, 0, 33);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
